// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Run-time programmable running-light generator for LED_NUM active-low LEDs.
// Four patterns: rotate left, rotate right, bounce and fill bar. Step period
// and pause are programmable. Step and wrap strobes let a buzzer or segment
// display follow the pattern.
//
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   mode       : 00 rotate left, 01 rotate right, 10 bounce, 11 fill
//   run_en     : 1 = advance, 0 = freeze counter and pattern
//   period     : clocks per step (0 behaves as 1)
//   led_out    : registered LED drive, active-low (0 = lit)
//   step_tick  : registered one-cycle pulse on every pattern step
//   wrap       : registered one-cycle pulse when the pattern returns to start
// ---------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int unsigned LED_NUM   = 4,
    parameter int unsigned CNT_WIDTH = 25
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [1:0]           mode,
    input  logic                 run_en,
    input  logic [CNT_WIDTH-1:0] period,
    output logic [LED_NUM-1:0]   led_out,
    output logic                 step_tick,
    output logic                 wrap
);

    localparam int unsigned POS_W  = $clog2(LED_NUM + 1);
    localparam int unsigned FILL_W = LED_NUM + 1;

    localparam logic [POS_W-1:0]   POS_LAST    = POS_W'(LED_NUM - 1);
    localparam logic [POS_W-1:0]   POS_FULL    = POS_W'(LED_NUM);
    localparam logic [LED_NUM-1:0] LED_START_N = ~LED_NUM'(1);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Registered state
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [POS_W-1:0]     pos_q;
    dir_t                 dir_q;
    mode_t                mode_q;

    // Next-state values
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [POS_W-1:0]     pos_d;
    dir_t                 dir_d;
    mode_t                mode_d;
    logic [LED_NUM-1:0]   led_d;
    logic                 tick_d;
    logic                 wrap_d;

    // Decoded conditions
    mode_t                mode_in;
    logic [CNT_WIDTH-1:0] period_eff;
    logic                 step_due;
    logic                 mode_chg;
    logic                 pos_bad;

    // Lit-LED pattern for a given mode and position. In fill mode pos counts
    // steps from the start state, so the lit count is pos+1, folding to 0
    // at pos = LED_NUM (all off). This keeps pos = 0 as the common start
    // state showing bit0 lit in every mode.
    function automatic logic [LED_NUM-1:0] lit_pattern(
        input mode_t            m,
        input logic [POS_W-1:0] p
    );
        logic [FILL_W-1:0] fill;
        logic [POS_W-1:0]  k;
        lit_pattern = LED_NUM'(1) << p;
        fill        = '0;
        k           = '0;
        if (m == MODE_FILL) begin
            k           = (p == POS_FULL) ? '0 : p + POS_W'(1);
            fill        = (FILL_W'(1) << k) - FILL_W'(1);
            lit_pattern = fill[LED_NUM-1:0];
        end
    endfunction

    // Step timing, mode-change and illegal-position detection.
    // The >= compare lets a mid-count period decrease step on the next edge.
    always_comb begin
        mode_in    = mode_t'(mode);
        period_eff = (period == '0) ? CNT_WIDTH'(1) : period;
        step_due   = run_en && (cnt_q >= (period_eff - CNT_WIDTH'(1)));
        mode_chg   = (mode_in != mode_q);
        pos_bad    = (mode_q == MODE_FILL) ? (pos_q > POS_FULL)
                                           : (pos_q > POS_LAST);
    end

    // Next-state and output logic
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;

        if (mode_chg) begin
            // Restart silently in the new mode, even while paused
            cnt_d  = '0;
            pos_d  = '0;
            dir_d  = DIR_UP;
            mode_d = mode_in;
        end else if (pos_bad) begin
            cnt_d = '0;
            pos_d = '0;
            dir_d = DIR_UP;
        end else if (step_due) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            case (mode_q)
                MODE_ROL: begin
                    if (pos_q == POS_LAST) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
                MODE_ROR: begin
                    pos_d  = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                    wrap_d = (pos_q == POS_W'(1));
                end
                MODE_BOUNCE: begin
                    // Endpoints shown once per pass: turn on arrival
                    if (dir_q == DIR_UP) begin
                        pos_d = pos_q + POS_W'(1);
                        if (pos_d == POS_LAST) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                        if (pos_d == '0) begin
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (pos_q == POS_FULL) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
                default: begin
                    pos_d = '0;
                end
            endcase
        end else if (run_en) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        // Display follows the next state so led_out updates with the strobes
        led_d = ~lit_pattern(mode_d, pos_d);
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q     <= '0;
            pos_q     <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_ROL;
            led_out   <= LED_START_N;
            step_tick <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            led_out   <= led_d;
            step_tick <= tick_d;
            wrap      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen (LED_NUM=4). A behavioural model
// tracks each mode as an index into its cyclic list of patterns plus a
// running clock count, and is compared with the DUT after every edge.
// Directed scenarios add literal expected LED values on top of the model.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 25;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [1:0]    mode;
    logic          run_en;
    logic [CW-1:0] period;
    logic [N-1:0]  led_out;
    logic          step_tick;
    logic          wrap;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode_q;
    int m_idx;
    int m_cnt;
    bit m_tick;
    bit m_wrap;

    logic [3:0] rol_exp  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [3:0] bnc_exp  [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                                 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] fill_exp [6] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000,
                                 4'b1111, 4'b1110};

    led_pattern_gen #(
        .LED_NUM   (N),
        .CNT_WIDTH (CW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mode      (mode),
        .run_en    (run_en),
        .period    (period),
        .led_out   (led_out),
        .step_tick (step_tick),
        .wrap      (wrap)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of distinct patterns in one cycle of each mode
    function automatic int seq_len(input int m);
        case (m)
            0, 1:    return N;
            2:       return 2 * N - 2;
            default: return N + 1;
        endcase
    endfunction

    // Lit pattern (1 = lit) at position idx of a mode's cycle
    function automatic logic [N-1:0] seq_pat(input int m, input int idx);
        longint unsigned x;
        int p;
        case (m)
            0:       p = idx;
            1:       p = (idx == 0) ? 0 : N - idx;
            2:       p = (idx < N) ? idx : 2 * N - 2 - idx;
            default: p = (idx + 1) % (N + 1);
        endcase
        if (m == 3) x = (64'd1 << p) - 64'd1;
        else        x = 64'd1 << p;
        return x[N-1:0];
    endfunction

    task automatic model_reset();
        m_mode_q = 0;
        m_idx    = 0;
        m_cnt    = 0;
        m_tick   = 1'b0;
        m_wrap   = 1'b0;
    endtask

    task automatic model_edge(input int md, input bit re, input int per);
        int pe;
        pe     = (per == 0) ? 1 : per;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (md != m_mode_q) begin
            m_mode_q = md;
            m_idx    = 0;
            m_cnt    = 0;
        end else if (re) begin
            if (m_cnt >= pe - 1) begin
                m_cnt  = 0;
                m_idx  = (m_idx + 1) % seq_len(m_mode_q);
                m_tick = 1'b1;
                m_wrap = (m_idx == 0);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] e;
        e = ~seq_pat(m_mode_q, m_idx);
        check_eq("model_led", 32'(led_out), 32'(e));
        check_eq("model_tick", 32'(step_tick), 32'(m_tick));
        check_eq("model_wrap", 32'(wrap), 32'(m_wrap));
    endtask

    // One clock: apply inputs, take the edge, check 1 time unit later
    task automatic cyc(input int md, input bit re, input int per);
        mode   = 2'(md);
        run_en = re;
        period = CW'(per);
        @(posedge sys_clk);
        model_edge(md, re, per);
        #1;
        compare_model();
    endtask

    // Reset asserted between edges, released on a falling edge
    task automatic async_reset_pulse();
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_async_led", 32'(led_out), 32'(4'b1110));
        check_eq("rst_async_tick", 32'(step_tick), 32'd0);
        check_eq("rst_async_wrap", 32'(wrap), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int r_mode;
        bit r_run;
        int r_per;
        bit found;

        sys_rst_n = 1'b0;
        mode      = 2'b00;
        run_en    = 1'b1;
        period    = CW'(3);
        model_reset();

        // Reset state
        #12;
        check_eq("reset_led", 32'(led_out), 32'(4'b1110));
        check_eq("reset_tick", 32'(step_tick), 32'd0);
        check_eq("reset_wrap", 32'(wrap), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Rotate left, P=3
        for (int c = 1; c <= 12; c++) begin
            cyc(0, 1'b1, 3);
            check_eq("rol_led", 32'(led_out), 32'(rol_exp[c / 3]));
            check_eq("rol_tick", 32'(step_tick), 32'((c % 3) == 0));
            check_eq("rol_wrap", 32'(wrap), 32'(c == 12));
        end

        // Bounce, P=1 (first edge is the mode-change restart)
        for (int i = 0; i < 7; i++) begin
            cyc(2, 1'b1, 1);
            check_eq("bnc_led", 32'(led_out), 32'(bnc_exp[i]));
            check_eq("bnc_tick", 32'(step_tick), 32'(i != 0));
            check_eq("bnc_wrap", 32'(wrap), 32'(i == 6));
        end

        // Fill, P=1
        for (int i = 0; i < 6; i++) begin
            cyc(3, 1'b1, 1);
            check_eq("fill_led", 32'(led_out), 32'(fill_exp[i]));
            check_eq("fill_tick", 32'(step_tick), 32'(i != 0));
            check_eq("fill_wrap", 32'(wrap), 32'(i == 5));
        end

        // Pause: P=10, run 4 clocks, freeze 20, then 6 more clocks to step
        cyc(0, 1'b1, 10);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'b1, 10);
            check_eq("pause_pre_tick", 32'(step_tick), 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1'b0, 10);
            check_eq("pause_hold_tick", 32'(step_tick), 32'd0);
            check_eq("pause_hold_led", 32'(led_out), 32'(4'b1110));
        end
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1'b1, 10);
            check_eq("resume_tick", 32'(step_tick), 32'(i == 6));
        end
        check_eq("resume_led", 32'(led_out), 32'(4'b1101));

        // Period cut below the running count steps on the next edge
        for (int i = 0; i < 7; i++) cyc(0, 1'b1, 10);
        check_eq("cut_pre_tick", 32'(step_tick), 32'd0);
        cyc(0, 1'b1, 3);
        check_eq("cut_tick", 32'(step_tick), 32'd1);
        check_eq("cut_led", 32'(led_out), 32'(4'b1011));

        // Period 0 steps every clock; ends showing 1011
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'b1, 0);
            check_eq("p0_tick", 32'(step_tick), 32'd1);
        end
        check_eq("p0_led", 32'(led_out), 32'(4'b1011));

        // Mode change 00 -> 01 while showing 1011
        cyc(1, 1'b1, 2);
        check_eq("mchg_led", 32'(led_out), 32'(4'b1110));
        check_eq("mchg_tick", 32'(step_tick), 32'd0);
        check_eq("mchg_wrap", 32'(wrap), 32'd0);
        cyc(1, 1'b1, 2);
        check_eq("mchg_cnt_tick", 32'(step_tick), 32'd0);
        cyc(1, 1'b1, 2);
        check_eq("mchg_step_led", 32'(led_out), 32'(4'b0111));
        check_eq("mchg_step_tick", 32'(step_tick), 32'd1);

        // Reset mid-operation while bouncing downward
        found = 1'b0;
        cyc(2, 1'b1, 1);
        for (int i = 0; i < 4; i++) cyc(2, 1'b1, 1);
        check_eq("pre_rst_led", 32'(led_out), 32'(4'b1011));
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_led", 32'(led_out), 32'(4'b1110));
        check_eq("midrst_tick", 32'(step_tick), 32'd0);
        check_eq("midrst_wrap", 32'(wrap), 32'd0);
        @(posedge sys_clk);
        #1;
        check_eq("midrst_hold_led", 32'(led_out), 32'(4'b1110));
        mode   = 2'b10;
        run_en = 1'b1;
        period = CW'(1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc(2, 1'b1, 1);
        check_eq("rel_restart_led", 32'(led_out), 32'(4'b1110));
        check_eq("rel_restart_tick", 32'(step_tick), 32'd0);
        cyc(2, 1'b1, 1);
        check_eq("rel_up_led", 32'(led_out), 32'(4'b1101));
        cyc(2, 1'b1, 1);
        check_eq("rel_up2_led", 32'(led_out), 32'(4'b1011));

        // Randomized operation against the model
        r_mode = 2;
        r_run  = 1'b1;
        r_per  = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) r_mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0)
                r_per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20))
                                                    : int'($urandom_range(0, 4));
            if ($urandom_range(0, 14) == 0) r_run = ~r_run;
            if ($urandom_range(0, 799) == 0) async_reset_pulse();
            cyc(r_mode, r_run, r_per);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
